// File: rtl/aes_inv_key_sched_if.sv
// Handshake and key bus between the inverse key schedule and its consumer.
// The slave modport is the key-schedule side; the master modport is the
// inverse-cipher round logic (or a testbench) side.
interface aes_inv_key_sched_if;
  logic         start;
  logic         key_is_last;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   key_round;
  logic         busy;
  logic         done;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  modport slave (
    input  start,
    input  key_is_last,
    input  key_in,
    input  key_ready,
    input  rd_round,
    output key_valid,
    output round_key,
    output key_round,
    output busy,
    output done,
    output rd_key
  );

  modport master (
    output start,
    output key_is_last,
    output key_in,
    output key_ready,
    output rd_round,
    input  key_valid,
    input  round_key,
    input  key_round,
    input  busy,
    input  done,
    input  rd_key
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule for the decryption datapath. Emits round keys from
// round 10 down to round 0 over a valid/ready handshake. Accepts either the
// cipher key (runs the forward expansion first) or the round-10 key.
// Optional key store enabled by defining AES_INV_KEY_STORE_EN; without it
// rd_key is tied to zero.
module aes_inv_key_sched #(
  parameter int unsigned NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_inv_key_sched_if.slave     bus
);

  localparam logic [3:0] LastRound = 4'(NR);

  // Forward S-box, byte 0x00 in the top byte of the constant.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StFwd, StEmit} state_e;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    int unsigned idx;
    idx = (32'd255 - 32'(b)) * 32'd8;
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd0:    c = 8'h01;
      4'd1:    c = 8'h02;
      4'd2:    c = 8'h04;
      4'd3:    c = 8'h08;
      4'd4:    c = 8'h10;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h40;
      4'd7:    c = 8'h80;
      4'd8:    c = 8'h1b;
      4'd9:    c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h000000};
  endfunction

  // Key r -> key r+1.
  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] v0, v1, v2, v3;
    v0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ rc;
    v1 = k[95:64] ^ v0;
    v2 = k[63:32] ^ v1;
    v3 = k[31:0] ^ v2;
    return {v0, v1, v2, v3};
  endfunction

  // Key r+1 -> key r. w3 must be recovered first since w0 depends on it.
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ rc;
    return {w0, w1, w2, w3};
  endfunction

  state_e         r_state;
  state_e         w_state_nxt;
  logic [127:0]   r_key;
  logic [127:0]   w_key_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           w_hs;

  assign w_hs = (r_state == StEmit) && bus.key_ready;

  // State, key and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_key   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, key update and done request.
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_key_nxt = bus.key_in;
          if (bus.key_is_last) begin
            w_cnt_nxt   = LastRound;
            w_state_nxt = StEmit;
          end else begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = StFwd;
          end
        end
      end
      StFwd: begin
        w_key_nxt = fwd_step(r_key, rcon(r_cnt));
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LastRound - 4'd1) begin
          w_state_nxt = StEmit;
        end
      end
      StEmit: begin
        if (bus.key_ready) begin
          if (r_cnt != 4'd0) begin
            w_key_nxt = inv_step(r_key, rcon(r_cnt - 4'd1));
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign bus.key_valid = (r_state == StEmit);
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = r_done;
  assign bus.round_key = r_key;
  assign bus.key_round = r_cnt;

`ifdef AES_INV_KEY_STORE_EN
  logic [127:0] r_store [0:10];
  logic [127:0] r_rd_key;

  // Capture each accepted key by round index; registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) begin
        r_store[i] <= '0;
      end
      r_rd_key <= '0;
    end else begin
      if (w_hs) begin
        r_store[r_cnt] <= r_key;
      end
      if (bus.rd_round <= LastRound) begin
        r_rd_key <= r_store[bus.rd_round];
      end else begin
        r_rd_key <= '0;
      end
    end
  end

  assign bus.rd_key = r_rd_key;
`else
  logic w_unused;
  assign w_unused   = ^{bus.rd_round, w_hs};
  assign bus.rd_key = '0;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched using FIPS-197 round keys.
module tb_aes_inv_key_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  aes_inv_key_sched_if bus ();

  aes_inv_key_sched #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] rk [0:10];

  typedef struct {
    logic         last;
    logic [127:0] key;
    int           lat;
    int           stall_at;
    int           nstall;
    bit           poke;
  } run_t;

  run_t runs [0:3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse start and wait (bounded) for key_valid; optionally pulse start in FWD.
  task automatic start_run(input logic last, input logic [127:0] k, input bit poke,
                           output int lat);
    bus.key_is_last = last;
    bus.key_in      = k;
    bus.start       = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.key_in = 128'h0f0e0d0c0b0a09080706050403020100;
    lat = 1;
    check("busy_after_start", 128'(bus.busy), 128'd1);
    while (!bus.key_valid && lat < 40) begin
      if (poke && lat == 5) begin
        bus.start       = 1'b1;
        bus.key_is_last = 1'b1;
        bus.key_in      = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      end else begin
        bus.start = 1'b0;
      end
      step();
      lat++;
    end
    bus.start = 1'b0;
  endtask

  // Accept all keys 10..0, optionally stalling at one round; ends on done cycle.
  task automatic drain(input int stall_at, input int nstall, input bit poke, output int nkeys);
    int exp_r;
    int stalls;
    int guard;
    exp_r  = 10;
    stalls = nstall;
    guard  = 0;
    nkeys  = 0;
    while (exp_r >= 0 && guard < 100) begin
      if (!bus.key_valid) begin
        check("key_valid_during_drain", 128'(bus.key_valid), 128'd1);
        break;
      end
      check("key_round", 128'(bus.key_round), 128'(exp_r));
      check("round_key", bus.round_key, rk[exp_r]);
      if (poke && exp_r == 8) begin
        bus.start       = 1'b1;
        bus.key_is_last = 1'b0;
        bus.key_in      = 128'h11111111222222223333333344444444;
      end else begin
        bus.start = 1'b0;
      end
      if (exp_r == stall_at && stalls > 0) begin
        bus.key_ready = 1'b0;
        stalls--;
      end else begin
        bus.key_ready = 1'b1;
        nkeys++;
        exp_r--;
      end
      step();
      guard++;
    end
    bus.start     = 1'b0;
    bus.key_ready = 1'b1;
    check("done_pulse", 128'(bus.done), 128'd1);
    check("busy_at_done", 128'(bus.busy), 128'd0);
  endtask

  initial begin
    int lat;
    int nkeys;
    int guard;
    int dcount;
    total = 0;
    bad   = 0;

    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    runs[0] = '{last: 1'b0, key: rk[0],  lat: 11, stall_at: -1, nstall: 0, poke: 1'b0};
    runs[1] = '{last: 1'b1, key: rk[10], lat: 1,  stall_at: -1, nstall: 0, poke: 1'b0};
    runs[2] = '{last: 1'b1, key: rk[10], lat: 1,  stall_at: 7,  nstall: 5, poke: 1'b0};
    runs[3] = '{last: 1'b0, key: rk[0],  lat: 11, stall_at: -1, nstall: 0, poke: 1'b1};

    bus.start       = 1'b0;
    bus.key_is_last = 1'b0;
    bus.key_in      = '0;
    bus.key_ready   = 1'b1;
    bus.rd_round    = 4'd0;
    rst             = 1'b1;
    #1;
    check("rst_key_valid", 128'(bus.key_valid), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_round_key", bus.round_key, 128'd0);
    check("rst_key_round", 128'(bus.key_round), 128'd0);
    check("rst_rd_key", bus.rd_key, 128'd0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      start_run(runs[i].last, runs[i].key, runs[i].poke, lat);
      check("latency", 128'(lat), 128'(runs[i].lat));
      drain(runs[i].stall_at, runs[i].nstall, runs[i].poke, nkeys);
      check("keys_emitted", 128'(nkeys), 128'd11);
      step();
      check("done_single", 128'(bus.done), 128'd0);
      check("idle_valid", 128'(bus.key_valid), 128'd0);
      step();
    end

    // Start on the same cycle as the done pulse.
    start_run(1'b1, rk[10], 1'b0, lat);
    drain(-1, 0, 1'b0, nkeys);
    bus.key_is_last = 1'b1;
    bus.key_in      = rk[10];
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_on_done_valid", 128'(bus.key_valid), 128'd1);
    check("restart_on_done_round", 128'(bus.key_round), 128'd10);
    drain(-1, 0, 1'b0, nkeys);
    check("restart_keys", 128'(nkeys), 128'd11);
    step();

    // Reset mid-emit at round 4.
    start_run(1'b1, rk[10], 1'b0, lat);
    guard = 0;
    while (bus.key_round != 4'd4 && guard < 40) begin
      step();
      guard++;
    end
    check("reached_round4", 128'(bus.key_round), 128'd4);
    rst = 1'b1;
    #1;
    check("midrst_valid", 128'(bus.key_valid), 128'd0);
    check("midrst_busy", 128'(bus.busy), 128'd0);
    dcount = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.done) dcount++;
      step();
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.done) dcount++;
      step();
    end
    check("midrst_no_done", 128'(dcount), 128'd0);
    start_run(1'b0, rk[0], 1'b0, lat);
    check("post_rst_latency", 128'(lat), 128'd11);
    drain(-1, 0, 1'b0, nkeys);
    check("post_rst_keys", 128'(nkeys), 128'd11);
    step();

`ifdef AES_INV_KEY_STORE_EN
    bus.rd_round = 4'd10;
    step();
    check("store_rd10", bus.rd_key, rk[10]);
    bus.rd_round = 4'd0;
    step();
    check("store_rd0", bus.rd_key, rk[0]);
    bus.rd_round = 4'd12;
    step();
    check("store_rd12", bus.rd_key, 128'd0);
`else
    bus.rd_round = 4'd10;
    step();
    check("rd_key_tied", bus.rd_key, 128'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
